// File: rtl/mem_arb_pkg.sv
// Shared defaults and width helpers for the memory port arbiter and its ID FIFO.
package mem_arb_pkg;

  localparam int NUM_CH_DEF    = 2;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_OUTST_DEF = 4;

  function automatic int id_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int cnt_width(input int max_outst);
    return $clog2(max_outst) + 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ID_W_DEF  = id_width(NUM_CH_DEF);
  localparam int CNT_W_DEF = cnt_width(MAX_OUTST_DEF);

endpackage

// File: rtl/arb_id_fifo.sv
// In-order queue of granted channel IDs; the head names the owner of the next response.
module arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W   = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ID_W-1:0]  id_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head_id = id_mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Explicit wrap keeps the pointers correct even for a single-entry queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) id_mem[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging sram-like requester channels onto one memory port,
// with a request lock while the memory stalls and in-order response routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_CH    = NUM_CH_DEF,
  parameter int  ADDR_W    = ADDR_W_DEF,
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  MAX_OUTST = MAX_OUTST_DEF,
  localparam int ID_W      = id_width(NUM_CH),
  localparam int CNT_W     = cnt_width(MAX_OUTST),
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*STRB_W-1:0] ch_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [STRB_W-1:0]        mem_wstrb,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_addr_ok,
  input  logic                     mem_data_ok,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [CNT_W-1:0]         outst_cnt,
  output logic                     err_spurious
);

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic                lock_vld_q, lock_vld_d;
  logic                err_q, err_d;
  logic [ID_W-1:0]     search_id, grant, head_id;
  logic                found, any_req, req_int, hs, pop;
  logic                fifo_full, fifo_empty;
  logic [2*NUM_CH-1:0] req2;
  logic [NUM_CH-1:0]   rot;
  logic [ADDR_W-1:0]   addr_a  [NUM_CH];
  logic [DATA_W-1:0]   wdata_a [NUM_CH];
  logic [STRB_W-1:0]   strb_a  [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign addr_a[gi]     = ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi]    = ch_wdata[gi*DATA_W +: DATA_W];
      assign strb_a[gi]     = ch_wstrb[gi*STRB_W +: STRB_W];
      assign ch_addr_ok[gi] = hs & (grant == ID_W'(gi));
      assign ch_data_ok[gi] = pop & (head_id == ID_W'(gi));
    end
  endgenerate

  // Rotating the request vector by rr_ptr turns the search into a fixed-priority pick.
  assign req2 = {ch_req, ch_req};
  assign rot  = NUM_CH'(req2 >> rr_ptr_q);

  always_comb begin
    search_id = rr_ptr_q;
    found     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && rot[k]) begin
        found     = 1'b1;
        search_id = ID_W'((int'(rr_ptr_q) + k) % NUM_CH);
      end
    end
  end

  assign grant   = lock_vld_q ? lock_id_q : search_id;
  assign any_req = |ch_req;
  assign req_int = resetn & (any_req | lock_vld_q) & ~fifo_full;
  assign hs      = req_int & mem_addr_ok;
  assign pop     = mem_data_ok & ~fifo_empty;

  assign mem_req      = req_int;
  assign mem_wr       = resetn & ch_wr[grant];
  assign mem_addr     = resetn ? addr_a[grant]  : '0;
  assign mem_wdata    = resetn ? wdata_a[grant] : '0;
  assign mem_wstrb    = resetn ? strb_a[grant]  : '0;
  assign ch_rdata     = resetn ? mem_rdata      : '0;
  assign err_spurious = err_q;

  // A stalled request pins the grant so the presented address cannot change under the memory.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    err_d      = err_q | (mem_data_ok & fifo_empty);
    if (hs) begin
      lock_vld_d = 1'b0;
      rr_ptr_d   = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end else if (req_int) begin
      lock_vld_d = 1'b1;
      lock_id_d  = grant;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      lock_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      lock_vld_q <= lock_vld_d;
      err_q      <= err_d;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (hs),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outst_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic
// against a queue-based model of round-robin grant, locking and in-order responses.
module tb_mem_port_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int MO  = 4;
  localparam int CW  = $clog2(MO) + 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [NCH*SW-1:0] ch_wstrb;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     ch_rdata;
  logic              mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [SW-1:0]     mem_wstrb;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [CW-1:0]     outst_cnt;
  logic              err_spurious;

  mem_port_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    logic          wr;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] rdata;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  // Reference model: pending requester transactions, grant pointer, lock, outstanding IDs.
  bit            pend    [NCH];
  logic          p_wr    [NCH];
  logic [SW-1:0] p_strb  [NCH];
  logic [AW-1:0] p_addr  [NCH];
  logic [DW-1:0] p_wdata [NCH];
  int            m_rr, m_lock;
  int            m_ids[$];
  bit            m_err;
  int            n_cmp, n_bad;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int model_grant();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < NCH; k++)
      if (pend[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
    return -1;
  endfunction

  task automatic raise(input int c, input logic [AW-1:0] a, input bit wr);
    pend[c]    = 1'b1;
    p_addr[c]  = a;
    p_wr[c]    = wr;
    p_strb[c]  = wr ? SW'($urandom) : '0;
    p_wdata[c] = $urandom;
  endtask

  task automatic model_reset();
    m_rr   = 0;
    m_lock = -1;
    m_err  = 1'b0;
    m_ids.delete();
    acc_q.delete();
    rsp_q.delete();
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
  endtask

  // One clock: drive at the falling edge, predict, check mid-low-phase, advance the model.
  task automatic step(input bit aok, input bit dok, input logic [DW-1:0] rd);
    int g;
    bit exp_req;
    int pre_n;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      ch_req[c]             = pend[c];
      ch_wr[c]              = p_wr[c];
      ch_wstrb[c*SW +: SW]  = p_strb[c];
      ch_addr[c*AW +: AW]   = p_addr[c];
      ch_wdata[c*DW +: DW]  = p_wdata[c];
    end
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    g       = model_grant();
    exp_req = (g >= 0) && (m_ids.size() < MO);
    pre_n   = m_ids.size();
    if (exp_req && aok)
      acc_q.push_back('{ch: g, wr: p_wr[g], strb: p_strb[g], addr: p_addr[g], wdata: p_wdata[g]});
    if (dok && pre_n > 0)
      rsp_q.push_back('{ch: m_ids[0], rdata: rd});
    #2;
    chk("mem_req", {63'd0, mem_req}, {63'd0, exp_req});
    chk("outst_cnt", 64'(outst_cnt), 64'(pre_n));
    chk("err_spurious", {63'd0, err_spurious}, {63'd0, m_err});
    if (dok) begin
      if (pre_n > 0) void'(m_ids.pop_front());
      else m_err = 1'b1;
    end
    if (exp_req) begin
      if (aok) begin
        m_ids.push_back(g);
        m_lock  = -1;
        m_rr    = (g + 1) % NCH;
        pend[g] = 1'b0;
      end else begin
        m_lock = g;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 32 && m_ids.size() > 0; i++) step(1'b0, 1'b1, $urandom);
  endtask

  // Reset asserted between edges; the count must clear before the next rising edge.
  task automatic async_reset();
    #1;
    resetn = 1'b0;
    model_reset();
    ch_req      = '1;
    mem_addr_ok = 1'b1;
    #1;
    chk("rst_outst_cnt", 64'(outst_cnt), 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_err", {63'd0, err_spurious}, 64'd0);
    ch_req      = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    @(negedge clk);
    #3;
    resetn = 1'b1;
  endtask

  // Monitor: compares whenever the DUT accepts/responds or the scoreboard expects it to.
  initial begin : monitor
    acc_t ea;
    rsp_t er;
    forever begin
      @(negedge clk);
      #2;
      if (ch_addr_ok != '0 || acc_q.size() != 0) begin
        if (acc_q.size() == 0) begin
          chk("accept_unexpected", 64'(ch_addr_ok), 64'd0);
        end else begin
          ea = acc_q.pop_front();
          chk("accept_onehot", 64'(ch_addr_ok), 64'(1) << ea.ch);
          chk("accept_addr", 64'(mem_addr), 64'(ea.addr));
          chk("accept_wr", {63'd0, mem_wr}, {63'd0, ea.wr});
          chk("accept_wstrb", 64'(mem_wstrb), 64'(ea.strb));
          chk("accept_wdata", 64'(mem_wdata), 64'(ea.wdata));
          $display("accept ch%0d wr=%0d addr=0x%08h t=%0t", ea.ch, ea.wr, ea.addr, $time);
        end
      end
      if (ch_data_ok != '0 || rsp_q.size() != 0) begin
        if (rsp_q.size() == 0) begin
          chk("response_unexpected", 64'(ch_data_ok), 64'd0);
        end else begin
          er = rsp_q.pop_front();
          chk("response_onehot", 64'(ch_data_ok), 64'(1) << er.ch);
          chk("response_rdata", 64'(ch_rdata), 64'(er.rdata));
          $display("response ch%0d rdata=0x%08h t=%0t", er.ch, er.rdata, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int order[5];
    order = '{0, 1, 2, 3, 0};
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    for (int c = 0; c < NCH; c++) begin
      p_wr[c] = 1'b0; p_strb[c] = '0; p_addr[c] = '0; p_wdata[c] = '0;
    end
    resetn      = 1'b0;
    ch_req      = '1;
    ch_wr       = '1;
    ch_wstrb    = '1;
    ch_addr     = '1;
    ch_wdata    = '1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    #12;
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_addr_ok", 64'(ch_addr_ok), 64'd0);
    chk("reset_data_ok", 64'(ch_data_ok), 64'd0);
    chk("reset_rdata", 64'(ch_rdata), 64'd0);
    chk("reset_outst_cnt", 64'(outst_cnt), 64'd0);
    chk("reset_err", {63'd0, err_spurious}, 64'd0);
    ch_req      = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    @(negedge clk);
    #3;
    resetn = 1'b1;

    // ch0 and ch1 together straight out of reset
    raise(0, $urandom, 1'b0);
    raise(1, $urandom, 1'b1);
    step(1'b1, 1'b0, '0);
    chk("rr_first_grant", 64'(ch_addr_ok), 64'b0001);
    step(1'b1, 1'b0, '0);
    chk("rr_second_grant", 64'(ch_addr_ok), 64'b0010);
    drain();

    // stalled ch1 read at 0x1c keeps the grant while ch0 waits
    raise(1, 32'h1c, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("lock_addr_c0", 64'(mem_addr), 64'h1c);
    raise(0, $urandom, 1'b1);
    for (int i = 1; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      chk("lock_addr_held", 64'(mem_addr), 64'h1c);
    end
    step(1'b1, 1'b0, '0);
    chk("lock_addr_accept", 64'(mem_addr), 64'h1c);
    chk("lock_grant_ch1", 64'(ch_addr_ok), 64'b0010);
    step(1'b1, 1'b0, '0);
    chk("after_lock_ch0", 64'(ch_addr_ok), 64'b0001);
    drain();

    // fill to MAX_OUTST, then one response reopens the port a cycle later
    for (int c = 0; c < NCH; c++) raise(c, $urandom, 1'($urandom));
    for (int i = 0; i < MO; i++) step(1'b1, 1'b0, '0);
    raise(0, $urandom, 1'b0);
    step(1'b1, 1'b0, '0);
    chk("full_outst_cnt", 64'(outst_cnt), 64'd4);
    chk("full_mem_req", {63'd0, mem_req}, 64'd0);
    step(1'b1, 1'b1, $urandom);
    chk("full_pop_req_low", {63'd0, mem_req}, 64'd0);
    step(1'b1, 1'b0, '0);
    chk("full_reopen_req", {63'd0, mem_req}, 64'd1);
    chk("full_reopen_ch0", 64'(ch_addr_ok), 64'b0001);
    drain();

    // responses return in accept order: ch0, ch1, ch0
    raise(0, $urandom, 1'b0); step(1'b1, 1'b0, '0);
    raise(1, $urandom, 1'b0); step(1'b1, 1'b0, '0);
    raise(0, $urandom, 1'b0); step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 32'hA);
    chk("order_rsp0_ok", 64'(ch_data_ok), 64'b0001);
    chk("order_rsp0_data", 64'(ch_rdata), 64'hA);
    step(1'b0, 1'b1, 32'hB);
    chk("order_rsp1_ok", 64'(ch_data_ok), 64'b0010);
    chk("order_rsp1_data", 64'(ch_rdata), 64'hB);
    step(1'b0, 1'b1, 32'hC);
    chk("order_rsp2_ok", 64'(ch_data_ok), 64'b0001);
    chk("order_rsp2_data", 64'(ch_rdata), 64'hC);

    // spurious response is sticky; then reset with two outstanding
    step(1'b0, 1'b1, $urandom);
    chk("spurious_no_data_ok", 64'(ch_data_ok), 64'd0);
    step(1'b0, 1'b0, '0);
    chk("spurious_set", {63'd0, err_spurious}, 64'd1);
    step(1'b0, 1'b0, '0);
    chk("spurious_sticky", {63'd0, err_spurious}, 64'd1);
    raise(0, $urandom, 1'b0);
    raise(1, $urandom, 1'b1);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("pre_reset_cnt", 64'(outst_cnt), 64'd2);
    async_reset();

    // four channels requesting continuously
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NCH; c++) if (!pend[c]) raise(c, $urandom, 1'($urandom));
      step(1'b1, i > 0, $urandom);
      chk("rr4_grant", 64'(ch_addr_ok), 64'(1) << order[i]);
    end
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if (!pend[c] && $urandom_range(0, 9) < 4) raise(c, $urandom, 1'($urandom));
      step($urandom_range(0, 9) < 6,
           (m_ids.size() > 0) ? 1'($urandom) : ($urandom_range(0, 29) == 0),
           $urandom);
    end
    for (int i = 0; i < 200; i++) begin
      if (m_ids.size() == 0 && !pend[0] && !pend[1] && !pend[2] && !pend[3]) break;
      step(1'b1, m_ids.size() > 0, $urandom);
    end
    @(negedge clk);
    #3;
    chk("final_outst_cnt", 64'(outst_cnt), 64'd0);
    chk("final_mem_req", {63'd0, mem_req}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of sram-like requester channels (2..8; ch0 = inst, ch1 = data).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter MAX_OUTST, default 4, maximum accepted-but-unanswered requests (power of 2, 1..16).
REQ-005 SHALL have clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ch_req  in  NUM_CH  per-channel request valid.
REQ-008 SHALL have ch_wr  in  NUM_CH  per-channel write (1) / read (0).
REQ-009 SHALL have ch_wstrb  in  NUM_CH*DATA_W/8  per-channel byte strobes, channel i at slice i.
REQ-010 SHALL have ch_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at slice i.
REQ-011 SHALL have ch_wdata  in  NUM_CH*DATA_W  per-channel write data, channel i at slice i.
REQ-012 SHALL have ch_addr_ok  out  NUM_CH  request accepted, one-hot or zero.
REQ-013 SHALL have ch_data_ok  out  NUM_CH  response returned, one-hot or zero.
REQ-014 SHALL have ch_rdata  out  DATA_W  read data, broadcast to all channels.
REQ-015 SHALL have mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  downstream request.
REQ-016 SHALL have mem_addr_ok, mem_data_ok  in  1/1; mem_rdata  in  DATA_W  downstream handshake and data.
REQ-017 SHALL have outst_cnt  out  clog2(MAX_OUTST)+1  current outstanding count.
REQ-018 SHALL have err_spurious  out  1  sticky flag: mem_data_ok seen with nothing outstanding.

Function
REQ-019 SHALL grant round-robin: search starts at rr_ptr, and the first channel with ch_req high wins.
REQ-020 SHALL drive mem_req = (any ch_req or lock_vld) & (outst_cnt < MAX_OUTST); mem_wr/wstrb/addr/wdata come from the granted channel.
REQ-021 SHALL pass mem_addr_ok combinationally to ch_addr_ok[grant] only when mem_req is high (0-cycle latency).
REQ-022 SHALL set lock_vld and lock_id = grant when mem_req=1 & mem_addr_ok=0; while locked, grant = lock_id regardless of other requests.
REQ-023 SHALL clear lock_vld and set rr_ptr = (grant+1) mod NUM_CH on each handshake (mem_req & mem_addr_ok).
REQ-024 SHALL push grant into an in-order ID FIFO on each handshake.
REQ-025 SHALL, on mem_data_ok with FIFO non-empty, pop the head, assert ch_data_ok[head] combinationally, and drive ch_rdata = mem_rdata.
REQ-026 SHALL increment outst_cnt on push only, decrement on pop only, and leave it unchanged on simultaneous push and pop.
REQ-027 SHALL, when full (outst_cnt = MAX_OUTST), hold mem_req at 0 even while locked; the lock persists, and a same-cycle pop does not reopen mem_req until the next cycle.
REQ-028 SHALL, on mem_data_ok with FIFO empty, keep ch_data_ok at 0, set err_spurious, and leave the count unchanged.
REQ-029 SHALL wrap FIFO pointers modulo MAX_OUTST; order across channels is strictly preserved.
REQ-030 SHALL have a grant value that is don't-care when no request and not locked; ch_addr_ok stays 0 in that case.

Reset
REQ-031 SHALL, on resetn=0 (async, any cycle including mid-transaction), clear the FIFO, set outst_cnt=0, rr_ptr=0, lock_vld=0, err_spurious=0; responses in flight are discarded.
REQ-032 SHALL hold all outputs at 0 during reset, with no ch_req influence on mem_req.

Structure
REQ-033 SHALL place the default parameters, the ID width (clog2(NUM_CH)) and the count width in shared package mem_arb_pkg.
REQ-034 SHALL implement the order queue as sub-module arb_id_fifo (depth MAX_OUTST, width ID_W, push/pop/full/empty/count).

Verification
REQ-035 SHALL cover: ch0 and ch1 request in the same cycle from reset, mem_addr_ok=1 -> ch0 granted first, then ch1 next cycle (rr_ptr=1).
REQ-036 SHALL cover: ch1 read addr 0x1c, mem_addr_ok low 3 cycles while ch0 also requests -> grant held on ch1 for 4 cycles, mem_addr=0x1c stable.
REQ-037 SHALL cover: with MAX_OUTST=4, 4 accepts with no data_ok -> outst_cnt=4, mem_req=0; one data_ok -> mem_req=1 next cycle.
REQ-038 SHALL cover: accepts ch0, ch1, ch0, then data_ok x3 with rdata 0xA/0xB/0xC -> ch_data_ok 01,10,01 with matching rdata.
REQ-039 SHALL cover: mem_data_ok with outst_cnt=0 -> err_spurious=1 and stays 1; resetn pulse mid-burst (2 outstanding) -> outst_cnt=0 asynchronously.
REQ-040 SHALL cover: NUM_CH=4 with all requesting continuously -> grant order 0,1,2,3,0.
